// File: rtl/asip_mem_pkg.sv
// Shared definitions for the ASIP data-memory responder: default widths,
// wait-counter width and the responder state type.
package asip_mem_pkg;

  localparam int DATA_W_DEF      = 24;
  localparam int ADDR_W_DEF      = 16;
  localparam int DEPTH_LOG2_DEF  = 10;
  localparam int WAIT_CYCLES_DEF = 2;

  // Wait counter holds 0..15 wait states.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_array.sv
// Synchronous single-port word storage. Contents are never cleared; only the
// registered read port returns to zero on reset.
module mem_array #(
  parameter int DATA_W     = 24,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  // Storage write; deliberately no reset so contents survive a core reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // Registered read; only updated by loads so the value holds between them.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the ASIP data-memory interface. One access in flight at a
// time; the core is stalled from request until the response cycle.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | ready for a request; accepting on req_valid
//   WAIT  | wait states counting down; access happens when counter reads 1
//   RESP  | one-cycle response strobe, no acceptance, then back to IDLE
module data_mem_responder
  import asip_mem_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DEPTH_LOG2  = DEPTH_LOG2_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              stall
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  // With no wait states the access is done at the acceptance edge itself,
  // straight from the request inputs.
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);

  mem_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic                  write_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  err_q;
  logic                  load_oor_q;

  logic                  req_oor;
  logic                  accept;
  logic                  access;
  logic                  acc_write;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic [DATA_W-1:0]     acc_wdata;
  logic                  acc_err;
  logic                  mem_en;
  logic [DATA_W-1:0]     mem_rdata;

  assign req_oor = |req_addr[ADDR_W-1:DEPTH_LOG2];

  // Next-state, wait counter and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    access    = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    stall     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid;
        if (req_valid) begin
          accept = 1'b1;
          cnt_d  = WAIT_LOAD;
          if (NO_WAIT) begin
            access  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt_q == CNT_ONE) begin
          access  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Access operands: live request when accessing from IDLE, latched otherwise.
  always_comb begin
    acc_write = write_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    acc_err   = err_q;
    if (state_q == IDLE) begin
      acc_write = req_write;
      acc_idx   = req_addr[DEPTH_LOG2-1:0];
      acc_wdata = req_wdata;
      acc_err   = req_oor;
    end
  end

  // Reset at the commit edge aborts the access; out-of-range stores are dropped.
  assign mem_en = access && !reset && !acc_err;

  // State, counter and response flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      load_oor_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        err_q <= req_oor;
      end
      if (access && !acc_write) begin
        load_oor_q <= acc_err;
      end
    end
  end

  // Request payload capture; only meaningful after acceptance, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= req_write;
      idx_q   <= req_addr[DEPTH_LOG2-1:0];
      wdata_q <= req_wdata;
    end
  end

  mem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem_array (
    .clk   (clk),
    .reset (reset),
    .en    (mem_en),
    .we    (acc_write),
    .addr  (acc_idx),
    .wdata (acc_wdata),
    .rdata (mem_rdata)
  );

  // Out-of-range loads read as zero until the next load replaces them.
  assign rsp_rdata = load_oor_q ? '0 : mem_rdata;
  assign rsp_err   = rsp_valid & err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus random
// transactions against an array-based reference of the memory contents.
module tb_data_mem_responder;

  localparam int DW = 24;
  localparam int AW = 16;
  localparam int DL = 10;
  localparam int W  = 2;

  logic          clk = 1'b0;
  logic          reset;

  logic          req_valid, req_write, req_ready, rsp_valid, rsp_err, stall;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata, rsp_rdata;

  logic          req_valid0, req_write0, req_ready0, rsp_valid0, rsp_err0, stall0;
  logic [AW-1:0] req_addr0;
  logic [DW-1:0] req_wdata0, rsp_rdata0;

  always #5 clk = ~clk;

  data_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(DL), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .stall(stall)
  );

  data_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(DL), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid0), .req_write(req_write0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_ready(req_ready0),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0), .stall(stall0)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference memory contents; a word is only compared once it has been written.
  logic [DW-1:0] ref_mem   [1 << DL];
  bit            ref_known [1 << DL];
  logic [DW-1:0] ref_rdata;
  bit            ref_rdata_known;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ref_rdata       = '0;
    ref_rdata_known = 1'b1;
  endtask

  // One request on the W=2 instance. junk: scramble request inputs (valid held
  // high) after acceptance. abort_k: assert reset in busy cycle k (0 = none).
  task automatic xact(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                      input bit junk, input int abort_k);
    bit            oor;
    int            idx;
    logic [DW-1:0] exp_rd;
    bit            rd_known;
    bit            committed;
    oor      = (addr[AW-1:DL] != '0);
    idx      = int'(addr[DL-1:0]);
    exp_rd   = '0;
    rd_known = 1'b1;
    if (!wr && !oor) begin
      exp_rd   = ref_mem[idx];
      rd_known = ref_known[idx];
    end

    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    #1;
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("idle_stall", 32'(stall), 32'd1);
    @(posedge clk);
    for (int k = 1; k <= W + 1; k++) begin
      @(negedge clk);
      if (junk) begin
        req_valid = 1'b1;
        req_write = 1'($urandom);
        req_addr  = AW'($urandom);
        req_wdata = DW'($urandom);
      end else begin
        req_valid = 1'b0;
      end
      #1;
      chk("rsp_valid", 32'(rsp_valid), 32'(k == W + 1));
      chk("busy_ready", 32'(req_ready), 32'd0);
      chk("busy_stall", 32'(stall), 32'(k <= W));
      if (k == W + 1) begin
        chk("rsp_err", 32'(rsp_err), 32'(oor));
        if (!wr && rd_known) chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
      end else begin
        chk("err_quiet", 32'(rsp_err), 32'd0);
      end
      if (k == abort_k) begin
        reset = 1'b1;
        break;
      end
    end

    committed = (abort_k == 0) || (abort_k > W);
    if (wr && !oor && committed) begin
      ref_mem[idx]   = wd;
      ref_known[idx] = 1'b1;
    end
    if (!wr) begin
      ref_rdata       = exp_rd;
      ref_rdata_known = rd_known;
    end
    if (abort_k != 0) begin
      ref_rdata       = '0;
      ref_rdata_known = 1'b1;
    end

    @(negedge clk);
    reset     = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("back_idle", 32'(req_ready), 32'd1);
    chk("rsp_done", 32'(rsp_valid), 32'd0);
    chk("err_low", 32'(rsp_err), 32'd0);
    chk("stall_idle", 32'(stall), 32'd0);
    if (ref_rdata_known) chk("rdata_hold", 32'(rsp_rdata), 32'(ref_rdata));
  endtask

  // Zero-wait instance: req_valid held high, one response every second cycle.
  task automatic run_nowait();
    bit            wr_l [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [AW-1:0] ad_l [8] = '{16'h0001, 16'h0002, 16'h0003, 16'h0002,
                                16'h0400, 16'h0003, 16'h0001, 16'h0001};
    logic [DW-1:0] m0 [4];
    bit            k0 [4];
    logic [DW-1:0] last_rd;
    logic [DW-1:0] wd;
    bit            oor;
    int            idx;
    for (int i = 0; i < 4; i++) k0[i] = 1'b0;
    last_rd = '0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      wd         = DW'($urandom);
      oor        = (ad_l[i][AW-1:DL] != '0);
      idx        = int'(ad_l[i][1:0]);
      req_valid0 = 1'b1;
      req_write0 = wr_l[i];
      req_addr0  = ad_l[i];
      req_wdata0 = wd;
      #1;
      chk("nw_ready", 32'(req_ready0), 32'd1);
      chk("nw_stall", 32'(stall0), 32'd1);
      chk("nw_idle_valid", 32'(rsp_valid0), 32'd0);
      @(negedge clk);
      #1;
      chk("nw_rsp_valid", 32'(rsp_valid0), 32'd1);
      chk("nw_resp_stall", 32'(stall0), 32'd0);
      chk("nw_resp_ready", 32'(req_ready0), 32'd0);
      chk("nw_err", 32'(rsp_err0), 32'(oor));
      if (!wr_l[i]) begin
        if (oor) last_rd = '0;
        else if (k0[idx]) last_rd = m0[idx];
        if (oor || k0[idx]) chk("nw_rdata", 32'(rsp_rdata0), 32'(last_rd));
      end else if (!oor) begin
        m0[idx] = wd;
        k0[idx] = 1'b1;
      end
      @(negedge clk);
    end
    req_valid0 = 1'b0;
    #1;
    chk("nw_hold", 32'(rsp_rdata0), 32'(last_rd));
    chk("nw_end_valid", 32'(rsp_valid0), 32'd0);
  endtask

  initial begin
    bit            wr;
    logic [AW-1:0] a;
    int            ab;

    for (int i = 0; i < (1 << DL); i++) ref_known[i] = 1'b0;
    reset      = 1'b1;
    req_valid  = 1'b0; req_write  = 1'b0; req_addr  = '0; req_wdata  = '0;
    req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = '0; req_wdata0 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rdata0", 32'(rsp_rdata0), 32'd0);
    req_valid = 1'b1;
    #1;
    chk("rst_stall_follows_valid", 32'(stall), 32'd1);
    req_valid = 1'b0;
    @(negedge clk);
    reset           = 1'b0;
    ref_rdata       = '0;
    ref_rdata_known = 1'b1;

    xact(1'b1, 16'h0005, 24'hABCDEF, 1'b0, 0);
    xact(1'b1, 16'h0006, 24'h000001, 1'b0, 0);
    pulse_reset();
    xact(1'b0, 16'h0006, 24'h0, 1'b0, 0);
    xact(1'b0, 16'h0005, 24'h0, 1'b0, 0);

    xact(1'b1, 16'h0000, 24'h5A5A5A, 1'b0, 0);
    xact(1'b1, 16'h0400, 24'h123456, 1'b0, 0);
    xact(1'b0, 16'h0400, 24'h0, 1'b0, 0);
    xact(1'b0, 16'h0000, 24'h0, 1'b0, 0);

    xact(1'b1, 16'h0010, 24'h111111, 1'b0, 0);
    xact(1'b1, 16'h0010, 24'h00FFFF, 1'b0, 2);
    xact(1'b0, 16'h0010, 24'h0, 1'b0, 0);

    xact(1'b1, 16'h0020, 24'h222222, 1'b0, 0);
    xact(1'b1, 16'h0020, 24'h333333, 1'b0, W + 1);
    xact(1'b0, 16'h0020, 24'h0, 1'b0, 0);

    xact(1'b1, 16'h0030, 24'hABC123, 1'b1, 0);
    xact(1'b0, 16'h0030, 24'h0, 1'b1, 0);

    xact(1'b0, 16'h0005, 24'h0, 1'b0, 0);
    xact(1'b1, 16'h0005, 24'h654321, 1'b0, 0);
    xact(1'b0, 16'h0005, 24'h0, 1'b0, 0);

    for (int n = 0; n < 80; n++) begin
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)
        a = AW'(($urandom_range(1, 63) << DL) | $urandom_range(0, 15));
      else
        a = AW'($urandom_range(0, 15));
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, W + 1)) : 0;
      xact(wr, a, DW'($urandom), 1'($urandom_range(0, 1)), ab);
    end

    run_nowait();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
